// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one SRAM-like memory port between instruction fetch and data access.
// Data requests win unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                mem_req,
    output logic                mem_wr,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_addr_ok,
    input  logic                mem_data_ok,
    input  logic [DATA_W-1:0]   mem_rdata,

    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

    state_t           state;
    state_t           next_state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             starve_hit;
    logic             grant_inst;
    logic             grant_data;

    // Fetch wins a tie only once it has been passed over the full limit
    always_comb begin
        starve_hit = (STARVE_LIMIT != 0) && (starve_cnt == CNT_MAX);
        grant_inst = inst_req && (!data_req || starve_hit);
        grant_data = data_req && !grant_inst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (grant_inst || grant_data) next_state = ADDR;
            ADDR: if (mem_addr_ok) next_state = DATA;
            DATA: if (mem_data_ok) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        inst_addr_ok = mem_addr_ok && (state == ADDR) && (owner == OWN_INST);
        data_addr_ok = mem_addr_ok && (state == ADDR) && (owner == OWN_DATA);
        inst_data_ok = mem_data_ok && (state == DATA) && (owner == OWN_INST);
        data_data_ok = mem_data_ok && (state == DATA) && (owner == OWN_DATA);
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Bus fields are latched once at the grant and held until the transaction retires
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
        end else begin
            mem_req <= (next_state == ADDR);
            busy    <= (next_state != IDLE);
            if (state == IDLE && grant_data) begin
                owner     <= OWN_DATA;
                mem_wr    <= data_wr;
                mem_wstrb <= data_wstrb;
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
                if (!inst_req) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != CNT_MAX) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (state == IDLE && grant_inst) begin
                owner      <= OWN_INST;
                mem_wr     <= 1'b0;
                mem_wstrb  <= {STRB_W{1'b0}};
                mem_addr   <= inst_addr;
                mem_wdata  <= '0;
                starve_cnt <= '0;
            end else if (state == DATA && mem_data_ok) begin
                owner <= OWN_NONE;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester agents, a bus slave model
// with programmable latency, and an in-order queue of expected bus transactions.
module tb_mem_port_arbiter;

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;
    logic        busy;

    int total = 0;
    int bad   = 0;

    txn_t        inst_q[$];
    txn_t        data_q[$];
    txn_t        exp_q[$];
    txn_t        resp_q[$];
    logic        inst_took = 1'b0;
    logic        data_took = 1'b0;

    int          addr_delay = 0;
    int          data_delay = 2;
    logic        force_dok  = 1'b0;
    int          phase = 0;
    int          cnt = 0;
    logic [31:0] lat_addr = '0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdata_fn(input logic [31:0] a);
        return (a == 32'h1C00_0000) ? 32'h0280_0C0C : (a ^ 32'h5A5A_5A5A);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Queue a request on its requester and record the bus transaction it should produce
    task automatic applyStimulus(input logic is_data, input logic wr, input logic [3:0] wstrb,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.is_data = is_data;
        t.wr      = wr;
        t.wstrb   = wstrb;
        t.addr    = addr;
        t.wdata   = wdata;
        if (is_data) data_q.push_back(t);
        else         inst_q.push_back(t);
        exp_q.push_back(t);
    endtask

    task automatic waitIdle(input string tag);
        logic done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && resp_q.size() == 0 && inst_q.size() == 0 &&
                data_q.size() == 0 && !busy && !mem_req)
                done = 1'b1;
        end
        if (!done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Requesters hold each request until its addr_ok was seen, then present the next one
    always @(posedge clk) begin
        #1;
        if (inst_took) begin void'(inst_q.pop_front()); inst_took = 1'b0; end
        if (data_took) begin void'(data_q.pop_front()); data_took = 1'b0; end
        inst_req = (inst_q.size() > 0);
        inst_addr = (inst_q.size() > 0) ? inst_q[0].addr : 32'h0;
        data_req = (data_q.size() > 0);
        if (data_q.size() > 0) begin
            data_wr    = data_q[0].wr;
            data_wstrb = data_q[0].wstrb;
            data_addr  = data_q[0].addr;
            data_wdata = data_q[0].wdata;
        end else begin
            data_wr    = 1'b0;
            data_wstrb = 4'h0;
            data_addr  = 32'h0;
            data_wdata = 32'h0;
        end
    end

    always @(posedge clk) begin
        #2;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'hBAD0_BAD0;
        if (rst) begin
            phase = 0;
        end else begin
            if (phase == 0 && mem_req) begin
                phase = 1;
                cnt   = addr_delay;
            end
            if (phase == 1) begin
                if (cnt == 0) begin
                    mem_addr_ok = 1'b1;
                    lat_addr    = mem_addr;
                    phase       = 2;
                    cnt         = data_delay;
                end else begin
                    cnt--;
                end
            end else if (phase == 2) begin
                if (cnt <= 1) begin
                    mem_data_ok = 1'b1;
                    mem_rdata   = rdata_fn(lat_addr);
                    phase       = 0;
                end else begin
                    cnt--;
                end
            end
            if (force_dok) mem_data_ok = 1'b1;
        end
    end

    always @(negedge clk) begin
        txn_t e;
        if (mem_req === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexp_req", {31'd0, mem_req}, 32'd0);
            end else begin
                checkOutput("bus_addr", mem_addr, exp_q[0].addr);
                checkOutput("bus_wr", {31'd0, mem_wr}, {31'd0, exp_q[0].wr});
                checkOutput("bus_wstrb", {28'd0, mem_wstrb}, {28'd0, exp_q[0].wstrb});
                checkOutput("bus_wdata", mem_wdata, exp_q[0].wdata);
            end
        end
        if (inst_addr_ok === 1'b1 || data_addr_ok === 1'b1) begin
            checkOutput("addr_ok_both", {31'd0, inst_addr_ok & data_addr_ok}, 32'd0);
            checkOutput("addr_ok_bus", {31'd0, mem_addr_ok}, 32'd1);
            if (exp_q.size() == 0) begin
                checkOutput("unexp_addr_ok", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("grant_side", {31'd0, data_addr_ok}, {31'd0, e.is_data});
                resp_q.push_back(e);
                if (data_addr_ok) data_took = 1'b1;
                else              inst_took = 1'b1;
            end
        end
        if (inst_data_ok === 1'b1 || data_data_ok === 1'b1) begin
            checkOutput("data_ok_both", {31'd0, inst_data_ok & data_data_ok}, 32'd0);
            if (resp_q.size() == 0) begin
                checkOutput("spurious_data_ok", 32'd1, 32'd0);
            end else begin
                e = resp_q.pop_front();
                checkOutput("resp_side", {31'd0, data_data_ok}, {31'd0, e.is_data});
                if (!e.wr)
                    checkOutput("rdata", data_data_ok ? data_rdata : inst_rdata, rdata_fn(e.addr));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic seen;
        rst = 1'b1;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);

        // Instruction fetch alone, with exact cycle timing
        @(posedge clk); #3;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h1C00_0000, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("i_c0_req", {31'd0, mem_req}, 32'd0);
        checkOutput("i_c0_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        checkOutput("i_c1_req", {31'd0, mem_req}, 32'd1);
        checkOutput("i_c1_aok", {31'd0, inst_addr_ok}, 32'd1);
        checkOutput("i_c1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("i_c2_req", {31'd0, mem_req}, 32'd0);
        checkOutput("i_c2_dok", {31'd0, inst_data_ok}, 32'd0);
        checkOutput("i_c2_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("i_c3_dok", {31'd0, inst_data_ok}, 32'd1);
        checkOutput("i_c3_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        checkOutput("i_c4_busy", {31'd0, busy}, 32'd0);
        waitIdle("inst");

        // Store with a slow bus accept
        addr_delay = 3;
        @(posedge clk); #3;
        applyStimulus(1'b1, 1'b1, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF);
        waitIdle("store");

        // Simultaneous load and fetch: data is served first
        addr_delay = 1;
        @(posedge clk); #3;
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_2000, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h1C00_0010, 32'h0);
        waitIdle("simul");

        // Continuous contention: D,D,D,D,I,D,D then the leftover fetch
        addr_delay = 0;
        data_delay = 1;
        @(posedge clk); #3;
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, (i % 2) == 1, (i % 2) == 1 ? 4'h3 : 4'h0,
                          32'h0000_3000 + 32'(i * 4), 32'h1111_0000 + 32'(i));
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h1C00_0100, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_3010, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_3014, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h1C00_0104, 32'h0);
        waitIdle("starve");

        // Reset while waiting for the response
        data_delay = 12;
        @(posedge clk); #3;
        applyStimulus(1'b1, 1'b0, 4'h0, 32'h0000_4000, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (busy && !mem_req && exp_q.size() == 0) seen = 1'b1;
        end
        checkOutput("rstdata_reach", {31'd0, seen}, 32'd1);
        @(posedge clk); #3 rst = 1'b1;
        @(posedge clk); #3 rst = 1'b0;
        resp_q.delete();
        @(negedge clk);
        checkOutput("rstdata_req", {31'd0, mem_req}, 32'd0);
        checkOutput("rstdata_busy", {31'd0, busy}, 32'd0);
        checkOutput("rstdata_dok", {31'd0, data_data_ok | inst_data_ok}, 32'd0);
        repeat (15) @(negedge clk);
        data_delay = 2;
        @(posedge clk); #3;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h1C00_0040, 32'h0);
        waitIdle("after_rst");

        // Stray responses in IDLE and in ADDR
        @(posedge clk); #3 force_dok = 1'b1;
        @(posedge clk); #3 force_dok = 1'b0;
        @(negedge clk);
        checkOutput("stray_idle_busy", {31'd0, busy}, 32'd0);
        addr_delay = 5;
        @(posedge clk); #3;
        applyStimulus(1'b0, 1'b0, 4'h0, 32'h1C00_0080, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_req) seen = 1'b1;
        end
        checkOutput("stray_addr_reach", {31'd0, seen}, 32'd1);
        @(posedge clk); #3 force_dok = 1'b1;
        @(posedge clk); #3 force_dok = 1'b0;
        @(negedge clk);
        checkOutput("stray_addr_req", {31'd0, mem_req}, 32'd1);
        checkOutput("stray_addr_busy", {31'd0, busy}, 32'd1);
        checkOutput("stray_addr_dok", {31'd0, inst_data_ok}, 32'd0);
        waitIdle("stray");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
